// File: rtl/host_read_port.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// host_read_port
//
// Responds to host bus read cycles. The host strobes are asynchronous, so each
// one is synchronised first. A read of the VRAM window fetches the addressed
// byte through the VRAM host-read port. A read of the bank register returns
// the current bank number. The byte is then presented for the top level to
// drive onto the host data bus. This block is the read-direction counterpart
// of the host write path, which owns bankReg.
//
// Ports
//   clk            dot clock
//   nrst           asynchronous active-low reset
//   hostBusAddr    host address within the current bank (stable while strobed)
//   nHostRMEM      host read strobe, active low, asynchronous
//   nHostWMEM      host write strobe, active low, asynchronous
//   nHostVRAMEn    VRAM window select, active low, asynchronous
//   nHostBankRegEn bank register select, active low, asynchronous
//   bankReg        current bank number from the write path
//   hostRdAddr     VRAM read address {bankReg, hostBusAddr}, held between reads
//   hostRdReq      one-cycle VRAM read request
//   hostData       VRAM read data, valid RD_LATENCY clocks after hostRdReq
//   hostRdData     byte to drive onto the host data bus
//   hostRdDataOE   1 = top level drives the host data bus with hostRdData
//   hostBusDir     transceiver direction: 1 = host to FPGA, 0 = FPGA to host
// -----------------------------------------------------------------------------
module host_read_port #(
  parameter int RD_LATENCY  = 1,  // 1..7
  parameter int SYNC_STAGES = 2   // 2..3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [10:0] hostBusAddr,
  input  logic        nHostRMEM,
  input  logic        nHostWMEM,
  input  logic        nHostVRAMEn,
  input  logic        nHostBankRegEn,
  input  logic [1:0]  bankReg,
  output logic [12:0] hostRdAddr,
  output logic        hostRdReq,
  input  logic [7:0]  hostData,
  output logic [7:0]  hostRdData,
  output logic        hostRdDataOE,
  output logic        hostBusDir
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRIVE = 2'd2
  } stateE;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY);

  // Strobe vector order: {read, write, VRAM select, bank register select}
  logic [SYNC_STAGES-1:0][3:0] syncChain;
  logic [3:0]                  syncOut;

  logic  rd;
  logic  wr;
  logic  vramSel;
  logic  bankSel;
  logic  startCond;
  logic  prevStart;
  logic  startEdge;
  logic  releaseCond;
  stateE state;
  stateE nextState;
  logic [2:0] latCnt;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers
  // ---------------------------------------------------------------------------
  // NOTE: the chains reset to all ones (strobes inactive) rather than zero, so
  // a strobe still held low when reset releases shows up as a fresh edge.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every stage samples its predecessor's value from before the clock edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      syncChain <= '1;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0],
                    {nHostRMEM, nHostWMEM, nHostVRAMEn, nHostBankRegEn}};
    end
  end

  assign syncOut = syncChain[SYNC_STAGES-1];
  assign rd      = ~syncOut[3];
  assign wr      = ~syncOut[2];
  assign vramSel = ~syncOut[1];
  assign bankSel = ~syncOut[0];

  // A read with a simultaneous write strobe is a bus conflict and is ignored.
  assign startCond   = rd & ~wr & (vramSel | bankSel);
  assign releaseCond = ~rd | ~(vramSel | bankSel);

  // Edge detection: a held strobe starts exactly one access.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prevStart <= 1'b0;
    end else begin
      prevStart <= startCond;
    end
  end

  assign startEdge = startCond & ~prevStart;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: nextState gets its default before the case, so no path through this
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        // VRAM select wins when both selects are asserted.
        if (startEdge) begin
          nextState = vramSel ? FETCH : DRIVE;
        end
      end
      FETCH: begin
        if (latCnt == 3'd0) begin
          nextState = DRIVE;
        end
      end
      DRIVE: begin
        if (releaseCond) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: registered outputs and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hostRdAddr   <= '0;
      hostRdReq    <= 1'b0;
      hostRdData   <= '0;
      hostRdDataOE <= 1'b0;
      hostBusDir   <= 1'b1;
      latCnt       <= '0;
    end else begin
      hostRdReq <= 1'b0;
      case (state)
        IDLE: begin
          if (startEdge) begin
            if (vramSel) begin
              hostRdAddr <= {bankReg, hostBusAddr};
              hostRdReq  <= 1'b1;
              latCnt     <= LAT_LOAD;
            end else begin
              hostRdData   <= {6'b0, bankReg};
              hostRdDataOE <= 1'b1;
              hostBusDir   <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (latCnt == 3'd0) begin
            // Data is always captured. If the host has already let go, the bus
            // is never turned around and DRIVE exits on the following cycle.
            hostRdData   <= hostData;
            hostRdDataOE <= ~releaseCond;
            hostBusDir   <= releaseCond;
          end else begin
            latCnt <= latCnt - 3'd1;
          end
        end
        DRIVE: begin
          if (releaseCond) begin
            hostRdDataOE <= 1'b0;
            hostBusDir   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_read_port.sv
`timescale 1ns/1ps
// Testbench for host_read_port. Two instances share the host pins: one with
// RD_LATENCY=1 and one with RD_LATENCY=3. Each gets its own VRAM responder.
// A cycle-level reference model predicts every output from the pin history.
// Directed scenarios pin absolute latencies and values with literals.
module tb_host_read_port;

  localparam int SYNC = 2;
  localparam int NDUT = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic [10:0] hostBusAddr = '0;
  logic nHostRMEM      = 1'b1;
  logic nHostWMEM      = 1'b1;
  logic nHostVRAMEn    = 1'b1;
  logic nHostBankRegEn = 1'b1;
  logic [1:0] bankReg  = '0;

  logic [NDUT-1:0][12:0] rdAddr;
  logic [NDUT-1:0]       rdReq;
  logic [NDUT-1:0]       oe;
  logic [NDUT-1:0]       dir;
  logic [NDUT-1:0][7:0]  rdData;
  logic [NDUT-1:0][7:0]  hostData;

  host_read_port #(.RD_LATENCY(1), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .nrst(nrst), .hostBusAddr(hostBusAddr),
    .nHostRMEM(nHostRMEM), .nHostWMEM(nHostWMEM), .nHostVRAMEn(nHostVRAMEn),
    .nHostBankRegEn(nHostBankRegEn), .bankReg(bankReg),
    .hostRdAddr(rdAddr[0]), .hostRdReq(rdReq[0]), .hostData(hostData[0]),
    .hostRdData(rdData[0]), .hostRdDataOE(oe[0]), .hostBusDir(dir[0])
  );

  host_read_port #(.RD_LATENCY(3), .SYNC_STAGES(SYNC)) dut3 (
    .clk(clk), .nrst(nrst), .hostBusAddr(hostBusAddr),
    .nHostRMEM(nHostRMEM), .nHostWMEM(nHostWMEM), .nHostVRAMEn(nHostVRAMEn),
    .nHostBankRegEn(nHostBankRegEn), .bankReg(bankReg),
    .hostRdAddr(rdAddr[1]), .hostRdReq(rdReq[1]), .hostData(hostData[1]),
    .hostRdData(rdData[1]), .hostRdDataOE(oe[1]), .hostBusDir(dir[1])
  );

  always #20 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      if (nFails <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0]  vram    [0:8191];
  logic [3:0]  pinHist [0:65535];  // {nR, nW, nV, nB} sampled at each edge
  logic [12:0] abHist  [0:65535];  // {bankReg, hostBusAddr} at each edge
  int edgeN = 0;                   // clock edges since reset released

  wire [3:0] pins = {nHostRMEM, nHostWMEM, nHostVRAMEn, nHostBankRegEn};

  always @(posedge clk) begin
    if (nrst && edgeN < 65535) begin
      edgeN++;
      pinHist[edgeN] = pins;
      abHist[edgeN]  = {bankReg, hostBusAddr};
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: timing derived from "strobe seen SYNC edges late, start on
  // the first edge it qualifies, data captured RD_LATENCY+1 edges later".
  // ---------------------------------------------------------------------------
  int         mPhase  [NDUT];  // 0 idle, 1 waiting for data, 2 presenting
  int         mCap    [NDUT];  // edge at which the fetched byte is captured
  logic [7:0] mPend   [NDUT];
  logic       expOE   [NDUT];
  logic       expDir  [NDUT];
  logic       expReq  [NDUT];
  logic [7:0] expData [NDUT];
  logic [12:0] expAddr[NDUT];
  int         vPend   [NDUT];  // VRAM responder countdown

  int   reqCount [NDUT];
  int   oeRise   [NDUT];
  int   oeFall   [NDUT];
  logic oePrev   [NDUT];

  // Synchronised view of the pins after edge k.
  function automatic logic [3:0] viewAt(input int k);
    int idx;
    idx = k - SYNC + 1;
    return (idx >= 1) ? pinHist[idx] : 4'hF;
  endfunction

  function automatic bit startOf(input logic [3:0] p);
    return !p[3] && p[2] && (!p[1] || !p[0]);
  endfunction

  function automatic bit releaseOf(input logic [3:0] p);
    return p[3] || (p[1] && p[0]);
  endfunction

  task automatic modelStep(input int d);
    int lat;
    logic [3:0] v1;
    logic [3:0] v2;
    lat = (d == 0) ? 1 : 3;
    v1  = viewAt(edgeN - 1);
    v2  = viewAt(edgeN - 2);
    expReq[d] = 1'b0;
    case (mPhase[d])
      0: begin
        if (startOf(v1) && !startOf(v2)) begin
          if (!v1[1]) begin
            expAddr[d] = abHist[edgeN];
            expReq[d]  = 1'b1;
            mPend[d]   = vram[abHist[edgeN]];
            mCap[d]    = edgeN + 1 + lat;
            mPhase[d]  = 1;
          end else begin
            expData[d] = {6'b0, abHist[edgeN][12:11]};
            expOE[d]   = 1'b1;
            expDir[d]  = 1'b0;
            mPhase[d]  = 2;
          end
        end
      end
      1: begin
        if (edgeN == mCap[d]) begin
          expData[d] = mPend[d];
          mPhase[d]  = 2;
          if (!releaseOf(v1)) begin
            expOE[d]  = 1'b1;
            expDir[d] = 1'b0;
          end
        end
      end
      default: begin
        if (releaseOf(v1)) begin
          expOE[d]  = 1'b0;
          expDir[d] = 1'b1;
          mPhase[d] = 0;
        end
      end
    endcase
  endtask

  // Single compare process: model step, compare, monitor, VRAM responder.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!nrst) begin
        edgeN      = 0;
        mPhase[d]  = 0;
        expOE[d]   = 1'b0;
        expDir[d]  = 1'b1;
        expReq[d]  = 1'b0;
        expData[d] = 8'h00;
        expAddr[d] = 13'h0;
        vPend[d]   = -1;
        oePrev[d]  = 1'b0;
      end else begin
        modelStep(d);
      end
      check((d == 0) ? "oe_L1"   : "oe_L3",   oe[d],     expOE[d]);
      check((d == 0) ? "dir_L1"  : "dir_L3",  dir[d],    expDir[d]);
      check((d == 0) ? "data_L1" : "data_L3", rdData[d], expData[d]);
      check((d == 0) ? "req_L1"  : "req_L3",  rdReq[d],  expReq[d]);
      check((d == 0) ? "addr_L1" : "addr_L3", rdAddr[d], expAddr[d]);
      check((d == 0) ? "oe_implies_dir0_L1" : "oe_implies_dir0_L3", oe[d] & dir[d], 1'b0);
      if (nrst) begin
        if (rdReq[d]) reqCount[d]++;
        if (oe[d] && !oePrev[d]) oeRise[d] = edgeN;
        if (!oe[d] && oePrev[d]) oeFall[d] = edgeN;
        oePrev[d] = oe[d];
        // VRAM: byte valid exactly RD_LATENCY cycles after the request cycle.
        if (rdReq[d]) vPend[d] = (d == 0) ? 1 : 3;
        else if (vPend[d] >= 0) vPend[d]--;
      end
      hostData[d] = (vPend[d] == 0) ? vram[rdAddr[d]] : 8'hFF;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic idlePins();
    nHostRMEM      = 1'b1;
    nHostWMEM      = 1'b1;
    nHostVRAMEn    = 1'b1;
    nHostBankRegEn = 1'b1;
  endtask

  task automatic clearMon();
    for (int d = 0; d < NDUT; d++) begin
      reqCount[d] = 0;
      oeRise[d]   = -1;
      oeFall[d]   = -1;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tFall;
  int tRel;

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom_range(0, 254));
    vram[13'h1123] = 8'h5A;
    vram[13'h07FF] = 8'hC3;
    vram[13'h1055] = 8'h96;
    clearMon();

    // Reset state
    nrst = 1'b0;
    tick(3);
    check("reset_oe",   oe[0],     1'b0);
    check("reset_dir",  dir[0],    1'b1);
    check("reset_data", rdData[0], 8'h00);
    check("reset_addr", rdAddr[0], 13'h0);
    check("reset_req",  rdReq[0],  1'b0);
    @(negedge clk);
    #2 nrst = 1'b1;
    tick(3);

    // VRAM read, bank 2, addr 0x123
    bankReg = 2'd2; hostBusAddr = 11'h123;
    tick(1);
    clearMon();
    tFall = edgeN;
    nHostVRAMEn = 1'b0; nHostRMEM = 1'b0;
    tick(12);
    check("vram_oe_latency_L1", oeRise[0] - tFall, 5);
    check("vram_oe_latency_L3", oeRise[1] - tFall, 7);
    check("vram_data_L1", rdData[0], 8'h5A);
    check("vram_data_L3", rdData[1], 8'h5A);
    check("vram_req_pulses_L1", reqCount[0], 1);
    check("vram_req_pulses_L3", reqCount[1], 1);
    check("vram_addr", rdAddr[0], 13'h1123);
    check("vram_dir_driving", dir[0], 1'b0);
    tRel = edgeN;
    nHostRMEM = 1'b1;
    tick(6);
    check("vram_oe_release_L1", oeFall[0] - tRel, 3);
    check("vram_oe_release_L3", oeFall[1] - tRel, 3);
    check("vram_dir_release", dir[0], 1'b1);
    idlePins();
    tick(4);

    // Bank register read, bankReg = 3
    bankReg = 2'd3;
    tick(1);
    clearMon();
    tFall = edgeN;
    nHostBankRegEn = 1'b0; nHostRMEM = 1'b0;
    tick(10);
    check("bank_data_L1", rdData[0], 8'h03);
    check("bank_data_L3", rdData[1], 8'h03);
    check("bank_oe_L1", oe[0], 1'b1);
    check("bank_no_req_L1", reqCount[0], 0);
    check("bank_no_req_L3", reqCount[1], 0);
    check("bank_oe_latency", oeRise[0] - tFall, 3);
    idlePins();
    tick(6);

    // Held read strobe: one access, data stable while VRAM bus reads 0xFF
    bankReg = 2'd1; hostBusAddr = 11'h2AB;
    tick(1);
    clearMon();
    nHostVRAMEn = 1'b0; nHostRMEM = 1'b0;
    tick(50);
    check("hold_req_pulses_L1", reqCount[0], 1);
    check("hold_req_pulses_L3", reqCount[1], 1);
    check("hold_data_L1", rdData[0], vram[13'h0AAB]);
    check("hold_data_L3", rdData[1], vram[13'h0AAB]);
    check("hold_oe_L3", oe[1], 1'b1);
    idlePins();
    tick(6);

    // Read and write strobes together: ignored
    clearMon();
    nHostVRAMEn = 1'b0; nHostRMEM = 1'b0; nHostWMEM = 1'b0;
    tick(20);
    check("rdwr_no_req_L1", reqCount[0], 0);
    check("rdwr_no_req_L3", reqCount[1], 0);
    check("rdwr_no_oe_L1", oeRise[0], 32'hFFFF_FFFF);
    check("rdwr_no_oe_L3", oeRise[1], 32'hFFFF_FFFF);
    idlePins();
    tick(6);

    // Both selects asserted: VRAM read wins
    bankReg = 2'd0; hostBusAddr = 11'h7FF;
    tick(1);
    clearMon();
    nHostVRAMEn = 1'b0; nHostBankRegEn = 1'b0; nHostRMEM = 1'b0;
    tick(15);
    check("both_sel_req", reqCount[0], 1);
    check("both_sel_data", rdData[0], 8'hC3);
    check("both_sel_addr", rdAddr[0], 13'h07FF);
    idlePins();
    tick(6);

    // Reset during DRIVE, strobe kept low through reset
    bankReg = 2'd2; hostBusAddr = 11'h055;
    tick(1);
    nHostVRAMEn = 1'b0; nHostRMEM = 1'b0;
    tick(12);
    check("pre_reset_oe", oe[0], 1'b1);
    @(negedge clk);
    #5 nrst = 1'b0;
    #1;
    check("async_reset_oe_L1",  oe[0],  1'b0);
    check("async_reset_dir_L1", dir[0], 1'b1);
    check("async_reset_oe_L3",  oe[1],  1'b0);
    check("async_reset_dir_L3", dir[1], 1'b1);
    tick(2);
    @(negedge clk);
    #2 nrst = 1'b1;
    clearMon();
    tick(15);
    check("post_reset_req_L1", reqCount[0], 1);
    check("post_reset_req_L3", reqCount[1], 1);
    check("post_reset_oe_edge_L1", oeRise[0], 5);
    check("post_reset_oe_edge_L3", oeRise[1], 7);
    check("post_reset_data", rdData[0], 8'h96);
    idlePins();
    tick(6);

    // Randomised traffic; the compare process checks every cycle
    for (int t = 0; t < 200; t++) begin
      int kind;
      kind        = $urandom_range(0, 5);
      bankReg     = 2'($urandom);
      hostBusAddr = 11'($urandom);
      tick(1);
      case (kind)
        0, 1: begin nHostVRAMEn = 1'b0; nHostRMEM = 1'b0; end
        2:    begin nHostBankRegEn = 1'b0; nHostRMEM = 1'b0; end
        3:    begin nHostVRAMEn = 1'b0; nHostBankRegEn = 1'b0; nHostRMEM = 1'b0; end
        4:    begin nHostVRAMEn = 1'b0; nHostRMEM = 1'b0; nHostWMEM = 1'b0; end
        default: begin nHostVRAMEn = 1'b0; nHostWMEM = 1'b0; end
      endcase
      tick($urandom_range(1, 14));
      idlePins();
      tick($urandom_range(1, 8));
    end
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/host_read_port.md
Name: host_read_port

Overview:
- Responder for host bus read cycles. It is the read-direction counterpart of the host write path that loads VRAM.
- It synchronizes the host strobes, fetches the addressed VRAM byte (or the bank register) and presents it for the host to read.
- It drives the data transceiver direction and the data output enable; the top level owns the hostBusData tristate.
- It sits between the host bus pins, the VRAM host-read port (hostAddr/hostData) and the bank register held by the write path.

Parameters:
RD_LATENCY, 1, clocks from a hostRdReq cycle until hostData is valid (legal range 1..7).
SYNC_STAGES, 2, flip-flop stages on each host strobe (legal 2..3).

Ports:
clk  input  1  VGA dot clock (25.175 MHz), global buffer.
nrst  input  1  asynchronous active-low reset.
hostBusAddr  input  11  host address within the current bank; must be stable while strobes are asserted.
nHostRMEM  input  1  host read strobe, active low, asynchronous.
nHostWMEM  input  1  host write strobe, active low, asynchronous.
nHostVRAMEn  input  1  VRAM window select, active low, asynchronous.
nHostBankRegEn  input  1  bank register select, active low, asynchronous.
bankReg  input  2  current bank number from the write path.
hostRdAddr  output  13  VRAM read address {bankReg, hostBusAddr}.
hostRdReq  output  1  one-cycle VRAM read request.
hostData  input  8  VRAM read data, valid RD_LATENCY clocks after hostRdReq.
hostRdData  output  8  byte to drive onto hostBusData.
hostRdDataOE  output  1  1 = top level drives hostBusData with hostRdData.
hostBusDir  output  1  transceiver direction: 1 = host→FPGA, 0 = FPGA→host.

Behaviour:
- Clock and reset: single clock clk. Reset nrst is asynchronous, active low; all registers clear immediately on assertion.
- Reset values: hostRdAddr=0, hostRdReq=0, hostRdData=0, hostRdDataOE=0, hostBusDir=1, state=IDLE, sync chains=all 1.
- Synchronization: each of nHostRMEM, nHostWMEM, nHostVRAMEn and nHostBankRegEn passes through SYNC_STAGES flip-flops. "rd" and "wr" below mean the synchronized, inverted strobes.
- Start condition, evaluated in IDLE only: rd=1, wr=0, at least one select asserted, and the previous synchronized sample was not a start. Detection is edge-based, so a held strobe produces exactly one access.
- Select priority: if VRAMEn and BankRegEn are both asserted, the access is a VRAM read. rd and wr asserted together is ignored; the bus is never driven.
- States: IDLE, FETCH, DRIVE.
- IDLE→FETCH (VRAM select), on the start edge:
  - latch hostRdAddr <= {bankReg, hostBusAddr};
  - hostRdReq <= 1 for exactly one cycle;
  - load latency counter (3 bits) <= RD_LATENCY.
- FETCH: counter decrements once per cycle. When it reaches 0:
  - hostRdData <= hostData;
  - state <= DRIVE;
  - hostRdDataOE <= 1 and hostBusDir <= 0, both in the same cycle.
- IDLE→DRIVE (bank register select), on the start edge: hostRdData <= {6'b0, bankReg}; OE=1, Dir=0 from the next cycle. hostRdReq stays 0.
- DRIVE: hostRdData is held stable. Exit to IDLE when rd=0 or both selects deasserted; OE<=0 and Dir<=1 in the same cycle.
- Strobe released during FETCH: the fetch completes, data is captured, then the FSM returns to IDLE on the next cycle without asserting OE.
- Invariant: hostRdDataOE=1 only when hostBusDir=0.
- Pin-to-data latency (VRAM read): SYNC_STAGES + 1 + RD_LATENCY + 1 clocks. Default 5 clocks ≈ 199 ns.
- hostRdAddr holds its value between accesses. hostRdReq is never asserted outside the IDLE→FETCH transition.
- Reset mid-access: OE drops and Dir returns to 1 asynchronously. After reset releases, a still-asserted strobe is treated as a new edge, because the sync chains reset to 1.

Test Plan:
- After reset: all outputs at reset values, including hostBusDir=1 and hostRdDataOE=0.
- VRAM read, bank 2, addr 0x123, VRAM returns 0x5A:
  - hostRdReq is one pulse with hostRdAddr=0x1123;
  - OE=1 and Dir=0 five clocks after nHostRMEM falls, with hostRdData=0x5A;
  - both deassert one clock after nHostRMEM is synchronized high.
- Bank register read with bankReg=3: hostRdData=0x03, OE asserts with no hostRdReq pulse; repeat with RD_LATENCY=3 and check that VRAM read OE moves out by 2 clocks.
- Hold nHostRMEM low for 50 clocks: exactly one hostRdReq; hostRdData stays stable while hostData changes to 0xFF.
- nHostWMEM and nHostRMEM low together: no hostRdReq, OE never 1. Both selects asserted: behaves as a VRAM read.
- Pulse nrst low during DRIVE: OE=0 and Dir=1 immediately. Release nrst with the strobe held low: a new single access completes.
- Throughout all scenarios: assert that OE=1 implies Dir=0 on every cycle.
